// File: rtl/seg7_scanner_pkg.sv
// Shared types and constants for the seg7_scanner display stage:
// scan states, blanking constants and the active-low hex font.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_GAP0 = 2'd0,
        S_ON0  = 2'd1,
        S_GAP1 = 2'd2,
        S_ON1  = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_LOW    = 2'b10;
    localparam logic [1:0] AN_HIGH   = 2'b01;
    localparam logic [1:0] LED_RST   = 2'b11;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F.
    localparam logic [0:15][6:0] FONT = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] font_lookup(input logic [3:0] hex);
        return FONT[hex];
    endfunction

endpackage

// File: rtl/seg7_scanner_if.sv
// Bus between the front-panel selector side and the seg7_scanner display stage.
interface seg7_scanner_if;
    logic [7:0] SEG_IN;
    logic [1:0] LED_IN;
    logic       DISP_EN;
    logic [1:0] AN_OUT;
    logic [6:0] SEG_OUT;
    logic [1:0] LED_OUT;

    modport master (
        output SEG_IN, LED_IN, DISP_EN,
        input  AN_OUT, SEG_OUT, LED_OUT
    );

    modport slave (
        input  SEG_IN, LED_IN, DISP_EN,
        output AN_OUT, SEG_OUT, LED_OUT
    );
endinterface

// File: rtl/seg7_scanner_hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decode.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = font_lookup(hex_i);

endmodule

// File: rtl/seg7_scanner.sv
// Two-digit time-multiplexed common-anode 7-segment scanner with per-slot blanking
// gap and per-frame snapshot. Optional macro SEG7_SCANNER_LZ_BLANK_EN blanks a leading zero.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic           CLK,
    input  logic           RST,
    seg7_scanner_if.slave  bus
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    // With no gap the frame opens directly on the low digit.
    localparam scan_state_e FIRST_STATE = (GAP_CYCLES == 0) ? S_ON0 : S_GAP0;

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    snap_q, snap_d;
    logic [1:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    led_q, led_d;
    logic          cnt_last_s;
    logic [3:0]    digit_s;
    logic [6:0]    font_s;

    hex_to_seg7 u_hex_to_seg7 (
        .hex_i (digit_s),
        .seg_o (font_s)
    );

    // Slot counter, scan FSM next state and frame snapshot.
    always_comb begin
        cnt_last_s = (cnt_q == CNT_LAST);
        cnt_d      = cnt_last_s ? '0 : cnt_q + CW'(1);
        state_d    = state_q;
        case (state_q)
            S_GAP0: begin
                if (cnt_q == GAP_LAST) state_d = S_ON0;
                else                   state_d = S_GAP0;
            end
            S_ON0: begin
                if (cnt_last_s) state_d = (GAP_CYCLES == 0) ? S_ON1 : S_GAP1;
                else            state_d = S_ON0;
            end
            S_GAP1: begin
                if (cnt_q == GAP_LAST) state_d = S_ON1;
                else                   state_d = S_GAP1;
            end
            S_ON1: begin
                if (cnt_last_s) state_d = (GAP_CYCLES == 0) ? S_ON0 : S_GAP0;
                else            state_d = S_ON1;
            end
            default: state_d = FIRST_STATE;
        endcase
        // Digits read the next snapshot so the first lit cycle of a frame is never stale.
        if ((state_q == FIRST_STATE) && (cnt_q == '0)) snap_d = bus.SEG_IN;
        else                                            snap_d = snap_q;
        digit_s = (state_q == S_ON1) ? snap_d[7:4] : snap_d[3:0];
    end

    // Output decode for the registered anode, cathode and LED values.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        led_d = bus.LED_IN;
        if (bus.DISP_EN) begin
            case (state_q)
                S_ON0: begin
                    an_d  = AN_LOW;
                    seg_d = font_s;
                end
                S_ON1: begin
`ifdef SEG7_SCANNER_LZ_BLANK_EN
                    if (snap_d[7:4] == 4'h0) begin
                        an_d  = AN_OFF;
                        seg_d = SEG_BLANK;
                    end else begin
                        an_d  = AN_HIGH;
                        seg_d = font_s;
                    end
`else
                    an_d  = AN_HIGH;
                    seg_d = font_s;
`endif
                end
                default: begin
                    an_d  = AN_OFF;
                    seg_d = SEG_BLANK;
                end
            endcase
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    // State, counter, snapshot and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FIRST_STATE;
            cnt_q   <= '0;
            snap_q  <= 8'h00;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            led_q   <= LED_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            led_q   <= led_d;
        end
    end

    assign bus.AN_OUT  = an_q;
    assign bus.SEG_OUT = seg_q;
    assign bus.LED_OUT = led_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner: one instance with a blanking gap, one without.
module tb_seg7_scanner;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic [1:0] led;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;
    int   pos_a, pos_b;
    logic [7:0] snap_a, snap_b;
    exp_t qa[$];
    exp_t qb[$];

    logic [6:0] font [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scanner_if ifa ();
    seg7_scanner_if ifb ();

    seg7_scanner #(.PRESCALE(8), .GAP_CYCLES(2)) dut_a (.CLK(CLK), .RST(rst_a), .bus(ifa));
    seg7_scanner #(.PRESCALE(8), .GAP_CYCLES(0)) dut_b (.CLK(CLK), .RST(rst_b), .bus(ifb));

    always #5 CLK = ~CLK;

    // Frame position pos counts 0..15; slot = pos/8, position in slot = pos%8.
    task automatic model(input logic rst, input logic [7:0] seg, input logic en,
                         input logic [1:0] led, input int gap,
                         inout int pos, inout logic [7:0] snap, output exp_t e);
        logic [3:0] d;
        logic       on;
        e.led = rst ? 2'b11 : led;
        if (rst) begin
            pos   = 0;
            snap  = 8'h00;
            e.an  = 2'b11;
            e.seg = 7'h7F;
        end else begin
            if (pos == 0) snap = seg;
            d  = (pos >= 8) ? snap[7:4] : snap[3:0];
            on = en && ((pos % 8) >= gap);
`ifdef SEG7_SCANNER_LZ_BLANK_EN
            if (pos >= 8 && d == 4'h0) on = 1'b0;
`endif
            if (on) begin
                e.an  = (pos >= 8) ? 2'b01 : 2'b10;
                e.seg = font[d];
            end else begin
                e.an  = 2'b11;
                e.seg = 7'h7F;
            end
            pos = (pos + 1) % 16;
        end
    endtask

    task automatic check(input string tag, input exp_t e,
                         input logic [1:0] an, input logic [6:0] seg, input logic [1:0] led);
        total++;
        assert (an === e.an) else begin
            bad++;
            $error("FAIL %s_an: observed %b expected %b", tag, an, e.an);
        end
        total++;
        assert (seg === e.seg) else begin
            bad++;
            $error("FAIL %s_seg: observed %h expected %h", tag, seg, e.seg);
        end
        total++;
        assert (led === e.led) else begin
            bad++;
            $error("FAIL %s_led: observed %b expected %b", tag, led, e.led);
        end
        total++;
        assert (an !== 2'b00) else begin
            bad++;
            $error("FAIL %s_an_both: observed %b expected not 00", tag, an);
        end
    endtask

    task automatic tick(input int n);
        exp_t ea, eb;
        for (int i = 0; i < n; i++) begin
            model(rst_a, ifa.SEG_IN, ifa.DISP_EN, ifa.LED_IN, 2, pos_a, snap_a, ea);
            qa.push_back(ea);
            model(rst_b, ifb.SEG_IN, ifb.DISP_EN, ifb.LED_IN, 0, pos_b, snap_b, eb);
            qb.push_back(eb);
            @(posedge CLK);
            #1;
            check("gap2", qa.pop_front(), ifa.AN_OUT, ifa.SEG_OUT, ifa.LED_OUT);
            check("gap0", qb.pop_front(), ifb.AN_OUT, ifb.SEG_OUT, ifb.LED_OUT);
        end
    endtask

    initial begin
        pos_a = 0; pos_b = 0; snap_a = 8'h00; snap_b = 8'h00;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.SEG_IN = 8'h3A; ifa.LED_IN = 2'b00; ifa.DISP_EN = 1'b1;
        ifb.SEG_IN = 8'h0F; ifb.LED_IN = 2'b00; ifb.DISP_EN = 1'b1;
        tick(3);
        rst_a = 1'b0; rst_b = 1'b0;
        // First frame shows A/3; SEG_IN changes mid-frame and lands next frame.
        tick(5);
        ifa.SEG_IN = 8'h5C;
        tick(27);
        // Display disabled for 5 cycles inside the low-digit slot.
        tick(3);
        ifa.DISP_EN = 1'b0;
        tick(5);
        ifa.DISP_EN = 1'b1;
        tick(24);
        // LED pass-through, including while the display is off.
        ifa.LED_IN = 2'b11; ifb.LED_IN = 2'b11;
        tick(1);
        ifa.LED_IN = 2'b01; ifb.LED_IN = 2'b01;
        ifa.DISP_EN = 1'b0; ifb.DISP_EN = 1'b0;
        tick(2);
        ifa.LED_IN = 2'b10; ifb.LED_IN = 2'b10;
        tick(1);
        ifa.DISP_EN = 1'b1; ifb.DISP_EN = 1'b1;
        tick(2);
        // Reset in the middle of the high-digit slot, new value with a zero high digit.
        for (int k = 0; k < 16 && pos_a != 12; k++) tick(1);
        rst_a = 1'b1;
        ifa.SEG_IN = 8'h07;
        tick(2);
        rst_a = 1'b0;
        tick(20);
        ifb.SEG_IN = 8'h00;
        tick(18);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
